// File: rtl/tinycpu_mem_pkg.sv
// Shared definitions for the tinycpu data-memory responder.
//   resp_state_e  : responder FSM states (idle, wait-state countdown, response held)
//   WordWidth     : data / address word width
//   DefaultDepth  : default number of words in the storage array
//   DefaultWait   : default number of wait-state cycles per response
package tinycpu_mem_pkg;

   localparam int unsigned WordWidth    = 32;
   localparam int unsigned DefaultDepth = 2048;
   localparam int unsigned DefaultWait  = 2;
   localparam int unsigned WaitCntWidth = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWaiting,
      StRespond
   } resp_state_e;

endpackage

// File: rtl/resp_mem_array.sv
// Word-addressed storage array: one write port, one synchronous read port.
//   clk   : clock
//   we    : write enable, writes wdata to mem[waddr] on the rising edge
//   waddr : write word index
//   wdata : write data
//   re    : read enable, captures mem[raddr] into rdata on the rising edge
//   raddr : read word index
//   rdata : registered read data, holds its value while re is low
// Contents are never reset.
module resp_mem_array
   import tinycpu_mem_pkg::*;
#(
   parameter int unsigned DEPTH = DefaultDepth,
   localparam int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AddrWidth-1:0] waddr,
   input  logic [WordWidth-1:0] wdata,
   input  logic                 re,
   input  logic [AddrWidth-1:0] raddr,
   output logic [WordWidth-1:0] rdata
);

   logic [WordWidth-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with a fixed number of wait states.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   req_valid : request present
//   req_ready : responder idle and able to accept a request
//   req_we    : 1 = store, 0 = load
//   req_addr  : word address (full 32 bits range-checked against DEPTH)
//   req_wdata : store data
//   rsp_valid : response present
//   rsp_ready : requester takes the response
//   rsp_rdata : load data, 0 for stores and out-of-range requests
//   rsp_err   : request address was out of range
// Stores commit to the array on the acceptance edge; loads read the array on the
// acceptance edge. The response appears WAIT+1 cycles after acceptance.
module data_mem_responder
   import tinycpu_mem_pkg::*;
#(
   parameter int unsigned DEPTH = DefaultDepth,
   parameter int unsigned WAIT  = DefaultWait
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [WordWidth-1:0] req_addr,
   input  logic [WordWidth-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WordWidth-1:0] rsp_rdata,
   output logic                 rsp_err
);

   localparam int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WordWidth-1:0] DepthWord = WordWidth'(DEPTH);
   localparam bit HasWait = (WAIT > 0);
   // Counter starts at WAIT-1 so WAITING lasts exactly WAIT cycles.
   localparam logic [WaitCntWidth-1:0] WaitLoad =
      HasWait ? WaitCntWidth'(WAIT - 1) : '0;

   resp_state_e             state_q, state_d;
   logic [WaitCntWidth-1:0] wait_cnt_q, wait_cnt_d;
   logic                    err_q, err_d;
   logic                    load_q, load_d;

   logic                    in_range;
   logic                    accept;
   logic                    mem_we;
   logic                    mem_re;
   logic [WordWidth-1:0]    mem_rdata;

   assign in_range = (req_addr < DepthWord);
   assign accept   = req_valid & req_ready;
   assign mem_we   = accept & req_we & in_range;
   assign mem_re   = accept & ~req_we & in_range;

   resp_mem_array #(
      .DEPTH(DEPTH)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .waddr(req_addr[AddrWidth-1:0]),
      .wdata(req_wdata),
      .re   (mem_re),
      .raddr(req_addr[AddrWidth-1:0]),
      .rdata(mem_rdata)
   );

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      load_d     = load_q;
      req_ready  = (state_q == StIdle);
      rsp_valid  = (state_q == StRespond);

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               err_d  = ~in_range;
               load_d = in_range & ~req_we;
               if (HasWait) begin
                  state_d    = StWaiting;
                  wait_cnt_d = WaitLoad;
               end else begin
                  state_d = StRespond;
               end
            end
         end
         StWaiting: begin
            if (wait_cnt_q == '0) begin
               state_d = StRespond;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         StRespond: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // The memory read register only loads on an accepted in-range load, so the
   // data stays stable for the whole RESPOND phase; gating keeps stores, errors
   // and non-responding states at zero.
   assign rsp_rdata = (rsp_valid & load_q) ? mem_rdata : '0;
   assign rsp_err   = rsp_valid & err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
         load_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         load_q     <= load_d;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 uses WAIT=2, instance 1 uses WAIT=0.
// A transaction-level model predicts handshakes and response contents every cycle;
// directed sequences add literal expectations.
module tb_data_mem_responder;

   localparam int unsigned Depth = 2048;
   localparam int unsigned WaitA = 2;
   localparam int unsigned WaitB = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        rsp_ready [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DEPTH(Depth),
      .WAIT (WaitA)
   ) dut_a (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[0]),
      .req_ready(req_ready[0]),
      .req_we   (req_we[0]),
      .req_addr (req_addr[0]),
      .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]),
      .rsp_err  (rsp_err[0])
   );

   data_mem_responder #(
      .DEPTH(Depth),
      .WAIT (WaitB)
   ) dut_b (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[1]),
      .req_ready(req_ready[1]),
      .req_we   (req_we[1]),
      .req_addr (req_addr[1]),
      .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]),
      .rsp_err  (rsp_err[1])
   );

   function automatic int wait_of(input int k);
      return (k == 0) ? int'(WaitA) : int'(WaitB);
   endfunction

   task automatic chk1(input int k, input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL inst%0d %s: got %b expected %b (t=%0t)", k, name, act, exp, $time);
      end
   endtask

   task automatic chk32(input int k, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL inst%0d %s: got %h expected %h (t=%0t)", k, name, act, exp, $time);
      end
   endtask

   // Transaction model: one request outstanding from acceptance until the
   // response handshake; the response becomes visible WAIT+1 cycles after the
   // acceptance cycle.
   logic [31:0] mm      [2][Depth];
   bit          m_out   [2];
   int          m_rcyc  [2];
   logic [31:0] m_rdata [2];
   bit          m_err   [2];
   int          m_cyc = 0;

   always @(posedge clk or negedge rst) begin
      bit valid_now;
      bit in_r;
      if (!rst) begin
         m_out[0] = 1'b0;
         m_out[1] = 1'b0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            valid_now = m_out[k] && (m_cyc >= m_rcyc[k]);
            if (!m_out[k] && req_valid[k]) begin
               in_r       = (req_addr[k] < Depth);
               m_err[k]   = !in_r;
               m_rdata[k] = 32'h0;
               if (in_r && req_we[k]) mm[k][req_addr[k][10:0]] = req_wdata[k];
               if (in_r && !req_we[k]) m_rdata[k] = mm[k][req_addr[k][10:0]];
               m_out[k]  = 1'b1;
               m_rcyc[k] = m_cyc + wait_of(k) + 1;
            end else if (valid_now && rsp_ready[k]) begin
               m_out[k] = 1'b0;
            end
         end
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      bit vn;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            chk1(k, "reset req_ready", req_ready[k], 1'b1);
            chk1(k, "reset rsp_valid", rsp_valid[k], 1'b0);
            chk32(k, "reset rsp_rdata", rsp_rdata[k], 32'h0);
            chk1(k, "reset rsp_err", rsp_err[k], 1'b0);
         end else begin
            vn = m_out[k] && (m_cyc >= m_rcyc[k]);
            chk1(k, "req_ready", req_ready[k], !m_out[k]);
            chk1(k, "rsp_valid", rsp_valid[k], vn);
            if (vn) begin
               chk32(k, "rsp_rdata", rsp_rdata[k], m_rdata[k]);
               chk1(k, "rsp_err", rsp_err[k], m_err[k]);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs(input int k);
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      rsp_ready[k] = 1'b1;
   endtask

   // One transaction with rsp_ready high and literal response expectations.
   task automatic txn(input int k, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err);
      int w;
      w = wait_of(k);
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      rsp_ready[k] = 1'b1;
      tick;
      // Junk that must be ignored while req_valid is low.
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b1;
      req_addr[k]  = 32'h3;
      req_wdata[k] = 32'hBAD0_BAD0;
      repeat (w) begin
         chk1(k, "lit rsp_valid early", rsp_valid[k], 1'b0);
         tick;
      end
      chk1(k, "lit rsp_valid", rsp_valid[k], 1'b1);
      chk32(k, "lit rsp_rdata", rsp_rdata[k], exp_rdata);
      chk1(k, "lit rsp_err", rsp_err[k], exp_err);
      tick;
      chk1(k, "lit req_ready after rsp", req_ready[k], 1'b1);
   endtask

   initial begin
      int acc;
      idle_inputs(0);
      idle_inputs(1);
      rst = 1'b0;
      repeat (3) tick;
      rst = 1'b1;
      tick;

      // WAIT=2: basic store/load, range errors, boundary words.
      txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0, 1'b0);
      txn(0, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0);
      txn(0, 1'b0, 32'd2048, 32'h0, 32'h0, 1'b1);
      txn(0, 1'b1, 32'h8000_0005, 32'hCAFE_F00D, 32'h0, 1'b1);
      txn(0, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0);
      txn(0, 1'b1, 32'd2047, 32'hFFFF_FFFF, 32'h0, 1'b0);
      txn(0, 1'b0, 32'd2047, 32'h0, 32'hFFFF_FFFF, 1'b0);
      txn(0, 1'b1, 32'd0, 32'h0000_0001, 32'h0, 1'b0);
      txn(0, 1'b0, 32'd0, 32'h0, 32'h0000_0001, 1'b0);
      txn(0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);

      // Back-pressure: response held for 10 cycles, new requests ignored.
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'd5;
      tick;
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b0;
      tick;
      tick;
      for (int i = 0; i < 10; i++) begin
         req_valid[0] = 1'b1;
         req_we[0]    = 1'b1;
         req_addr[0]  = 32'd5;
         req_wdata[0] = 32'h1111_1111;
         chk1(0, "stall req_ready", req_ready[0], 1'b0);
         chk1(0, "stall rsp_valid", rsp_valid[0], 1'b1);
         chk32(0, "stall rsp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
         tick;
      end
      rsp_ready[0] = 1'b1;
      tick;
      req_valid[0] = 1'b0;
      chk1(0, "release req_ready", req_ready[0], 1'b1);
      chk1(0, "release rsp_valid", rsp_valid[0], 1'b0);
      txn(0, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0);

      // Reset during WAITING of a store: no response, store stays committed.
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'd7;
      req_wdata[0] = 32'h0000_1234;
      tick;
      idle_inputs(0);
      chk1(0, "waiting req_ready", req_ready[0], 1'b0);
      rst = 1'b0;
      #1;
      chk1(0, "mid reset req_ready", req_ready[0], 1'b1);
      chk1(0, "mid reset rsp_valid", rsp_valid[0], 1'b0);
      tick;
      rst = 1'b1;
      repeat (4) begin
         chk1(0, "post reset rsp_valid", rsp_valid[0], 1'b0);
         tick;
      end
      txn(0, 1'b0, 32'd7, 32'h0, 32'h0000_1234, 1'b0);

      // WAIT=0 throughput: req_valid held high, one acceptance every 2 cycles.
      acc = 0;
      rsp_ready[1] = 1'b1;
      req_valid[1] = 1'b1;
      for (int j = 0; j < 16; j++) begin
         int i;
         i = j / 2;
         if (i < 4) begin
            req_we[1]    = 1'b1;
            req_addr[1]  = 32'(10 + i);
            req_wdata[1] = 32'(32'hA0 + i);
         end else begin
            req_we[1]    = 1'b0;
            req_addr[1]  = 32'(10 + i - 4);
            req_wdata[1] = 32'h0;
         end
         if (req_ready[1]) acc++;
         tick;
         if (j == 7) chk32(1, "acceptances in 8 cycles", 32'(acc), 32'd4);
      end
      chk32(1, "acceptances in 16 cycles", 32'(acc), 32'd8);
      req_valid[1] = 1'b0;
      tick;
      txn(1, 1'b0, 32'd13, 32'h0, 32'h0000_00A3, 1'b0);
      txn(1, 1'b0, 32'd2048, 32'h0, 32'h0, 1'b1);

      tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
